// File: rtl/escalonador_contexto.sv
// Round-robin context scheduler: saves the interrupted PC, scans the process
// table for the next runnable entry and issues a one-cycle PC load to fetch.
module escalonador_contexto #(
  parameter int NUM_PROC = 4,
  parameter int PID_W    = 2,
  parameter int PC_W     = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             troca_contexto,
  input  logic             intrucaoIOContexto,
  input  logic             fimProcesso,
  input  logic [PC_W-1:0]  pc_processo_trocado,
  input  logic             cria_processo,
  input  logic [PID_W-1:0] cria_id,
  input  logic [PC_W-1:0]  cria_pc,
  input  logic             io_concluido,
  input  logic [PID_W-1:0] io_id,
  output logic             carrega_pc,
  output logic [PC_W-1:0]  pc_novo,
  output logic [PID_W-1:0] processo_atual,
  output logic             ocupado,
  output logic             ocioso
);

  typedef enum logic [2:0] {EXEC, SALVA, BUSCA, CARREGA, OCIOSO} estado_t;

  estado_t estado, prox;

  logic troca_q, io_q, fim_q;
  logic troca_e, io_e, fim_e;

  logic [NUM_PROC-1:0] valido, bloqueado, executavel;
  logic [PC_W-1:0]     tabela_pc [NUM_PROC];

  logic [PC_W-1:0]  pc_salvo;
  logic             bloq_pend;
  logic [PID_W-1:0] ptr;
  logic [PID_W-1:0] cnt;

  logic             latch_pc, pend_val, inicia_busca, avanca;
  logic             sel;
  logic [PID_W-1:0] sel_id;
  logic             salva_wr, clr_valido;
  logic             achou;
  logic [PID_W-1:0] id_livre;

  assign troca_e = troca_contexto & ~troca_q;
  assign io_e    = intrucaoIOContexto & ~io_q;
  assign fim_e   = fimProcesso & ~fim_q;

  assign executavel = valido & ~bloqueado;

  assign carrega_pc = (estado == CARREGA);
  assign ocupado    = (estado != EXEC);
  assign ocioso     = (estado == OCIOSO);

  // While idle, the lowest-numbered runnable entry wins.
  always_comb begin
    achou    = 1'b0;
    id_livre = '0;
    for (int i = NUM_PROC - 1; i >= 0; i--) begin
      if (executavel[i]) begin
        achou    = 1'b1;
        id_livre = PID_W'(i);
      end
    end
  end

  always_comb begin
    prox         = estado;
    latch_pc     = 1'b0;
    pend_val     = 1'b0;
    inicia_busca = 1'b0;
    avanca       = 1'b0;
    sel          = 1'b0;
    sel_id       = ptr;
    salva_wr     = 1'b0;
    clr_valido   = 1'b0;
    case (estado)
      EXEC: begin
        if (fim_e) begin
          clr_valido   = 1'b1;
          inicia_busca = 1'b1;
          prox         = BUSCA;
        end else if (troca_e) begin
          latch_pc = 1'b1;
          prox     = SALVA;
        end else if (io_e) begin
          latch_pc = 1'b1;
          pend_val = 1'b1;
          prox     = SALVA;
        end
      end
      SALVA: begin
        salva_wr     = 1'b1;
        inicia_busca = 1'b1;
        prox         = BUSCA;
      end
      BUSCA: begin
        if (executavel[ptr]) begin
          sel    = 1'b1;
          sel_id = ptr;
          prox   = CARREGA;
        end else if (cnt == PID_W'(NUM_PROC - 1)) begin
          prox = OCIOSO;
        end else begin
          avanca = 1'b1;
        end
      end
      CARREGA: prox = EXEC;
      OCIOSO: begin
        if (achou) begin
          sel    = 1'b1;
          sel_id = id_livre;
          prox   = CARREGA;
        end
      end
      default: prox = EXEC;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado         <= EXEC;
      troca_q        <= 1'b0;
      io_q           <= 1'b0;
      fim_q          <= 1'b0;
      pc_salvo       <= '0;
      bloq_pend      <= 1'b0;
      ptr            <= '0;
      cnt            <= '0;
      processo_atual <= '0;
      pc_novo        <= '0;
    end else begin
      estado  <= prox;
      troca_q <= troca_contexto;
      io_q    <= intrucaoIOContexto;
      fim_q   <= fimProcesso;
      if (latch_pc) begin
        pc_salvo  <= pc_processo_trocado;
        bloq_pend <= pend_val;
      end
      // Scan begins just after the current process and ends on it.
      if (inicia_busca) begin
        ptr <= processo_atual + PID_W'(1);
        cnt <= '0;
      end else if (avanca) begin
        ptr <= ptr + PID_W'(1);
        cnt <= cnt + PID_W'(1);
      end
      if (sel) begin
        processo_atual <= sel_id;
        pc_novo        <= tabela_pc[sel_id];
      end
    end
  end

  // External ports are applied last so they override the SALVA write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valido    <= '0;
      bloqueado <= '0;
      for (int i = 0; i < NUM_PROC; i++) tabela_pc[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PROC; i++) begin
        if (salva_wr && processo_atual == PID_W'(i)) begin
          tabela_pc[i] <= pc_salvo;
          if (bloq_pend) bloqueado[i] <= 1'b1;
        end
        if (clr_valido && processo_atual == PID_W'(i)) valido[i] <= 1'b0;
        if (io_concluido && io_id == PID_W'(i)) bloqueado[i] <= 1'b0;
        if (cria_processo && cria_id == PID_W'(i)) begin
          valido[i]    <= 1'b1;
          bloqueado[i] <= 1'b0;
          tabela_pc[i] <= cria_pc;
        end
      end
    end
  end

endmodule
